ice_bridge: RTL and testbench

- Byte-level in-circuit-emulator (ICE) command engine. It sits between the uart_rx/uart_tx FIFOs and the CPU core, on the CPU clock domain.
- It decodes nibble-packed command bytes from the host, assembles 16-bit address and data registers, and performs word reads and writes on the program RAM through a request/grant port shared with the core.
- It controls core reset, halt and single-step, and returns read results to the host as byte pairs through the TX FIFO.

---
 rtl/ice_pkg.sv | 38 +++
 rtl/ice_bridge.sv | 163 ++++++++++++++++
 tb/tb_ice_bridge.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ice_pkg.sv
// Command codes, control sub-codes, FSM encoding and nibble-insert helper
// shared by the ICE command engine.
package ice_pkg;

  localparam logic [3:0] ICE_CMD_WRITE = 4'd8;
  localparam logic [3:0] ICE_CMD_READ  = 4'd9;
  localparam logic [3:0] ICE_CMD_DUMP  = 4'd10;
  localparam logic [3:0] ICE_CMD_CTRL  = 4'd11;

  localparam logic [3:0] ICE_CTL_RUN     = 4'd0;
  localparam logic [3:0] ICE_CTL_RESET   = 4'd1;
  localparam logic [3:0] ICE_CTL_HALT    = 4'd2;
  localparam logic [3:0] ICE_CTL_RESUME  = 4'd3;
  localparam logic [3:0] ICE_CTL_STEP    = 4'd4;
  localparam logic [3:0] ICE_CTL_RSVD    = 4'd5;
  localparam logic [3:0] ICE_CTL_READ_PC = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_MEM_REQ,
    ST_MEM_ACC,
    ST_MEM_WAIT,
    ST_TX_HI,
    ST_TX_LO
  } ice_state_e;

  // Replace nibble 'sel' (bits 4*sel+3 : 4*sel) of a 16-bit register.
  function automatic logic [15:0] nib_insert(input logic [15:0] word,
                                             input logic [1:0]  sel,
                                             input logic [3:0]  nib);
    logic [15:0] r;
    r = word;
    r[{sel, 2'b00} +: 4] = nib;
    return r;
  endfunction

endpackage

// File: rtl/ice_bridge.sv
// Byte-level ICE command engine: decodes host nibble commands, does RAM word
// reads/writes via request/grant, controls core reset/halt/step, returns bytes.
module ice_bridge
  import ice_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              I_RESET,
  input  logic [7:0]        I_RX_DATA,
  input  logic              I_RX_PRESENT,
  output logic              O_RX_READ,
  output logic [7:0]        O_TX_DATA,
  output logic              O_TX_WRITE,
  input  logic              I_TX_FULL,
  output logic              O_MEM_REQ,
  input  logic              I_MEM_GNT,
  output logic              O_MEM_WE,
  output logic [ADDR_W-1:0] O_MEM_ADDR,
  output logic [15:0]       O_MEM_WDATA,
  input  logic [15:0]       I_MEM_RDATA,
  output logic              O_CORE_RESET,
  output logic              O_CORE_HALT,
  output logic              O_CORE_STEP,
  input  logic [15:0]       I_CORE_PC
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_LAT - 1);

  ice_state_e     state_q, state_d;
  logic [7:0]     byte_q, byte_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    data_q, data_d;
  logic           core_rst_q, core_rst_d;
  logic           halt_q, halt_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [3:0] cmd, nib;
  assign cmd = byte_q[7:4];
  assign nib = byte_q[3:0];

  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      state_q    <= ST_IDLE;
      byte_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      core_rst_q <= 1'b0;
      halt_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      core_rst_q <= core_rst_d;
      halt_q     <= halt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    data_d      = data_q;
    core_rst_d  = core_rst_q;
    halt_d      = halt_q;
    cnt_d       = cnt_q;
    O_RX_READ   = 1'b0;
    O_TX_WRITE  = 1'b0;
    O_TX_DATA   = 8'h00;
    O_MEM_REQ   = 1'b0;
    O_MEM_WE    = 1'b0;
    O_CORE_STEP = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (I_RX_PRESENT) begin
          O_RX_READ = 1'b1;
          byte_d    = I_RX_DATA;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (cmd < 4'd4) begin
          addr_d = nib_insert(addr_q, byte_q[5:4], nib);
        end else if (cmd < 4'd8) begin
          data_d = nib_insert(data_q, byte_q[5:4], nib);
        end else if (cmd == ICE_CMD_WRITE || cmd == ICE_CMD_READ) begin
          state_d = ST_MEM_REQ;
        end else if (cmd == ICE_CMD_DUMP) begin
          state_d = ST_TX_HI;
        end else if (cmd == ICE_CMD_CTRL) begin
          case (nib)
            ICE_CTL_RUN:     core_rst_d  = 1'b0;
            ICE_CTL_RESET:   core_rst_d  = 1'b1;
            ICE_CTL_HALT:    halt_d      = 1'b1;
            ICE_CTL_RESUME:  halt_d      = 1'b0;
            ICE_CTL_STEP:    O_CORE_STEP = halt_q;
            ICE_CTL_READ_PC: data_d      = I_CORE_PC;
            default: ;
          endcase
        end
      end
      ST_MEM_REQ: begin
        O_MEM_REQ = 1'b1;
        if (I_MEM_GNT) state_d = ST_MEM_ACC;
      end
      ST_MEM_ACC: begin
        O_MEM_REQ = 1'b1;
        O_MEM_WE  = (cmd == ICE_CMD_WRITE) && I_MEM_GNT;
        cnt_d     = '0;
        state_d   = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        // Address stays on the bus through the wait so read data lines up.
        O_MEM_REQ = 1'b1;
        if (cnt_q == WAIT_LAST) begin
          if (cmd == ICE_CMD_READ) data_d = I_MEM_RDATA;
          addr_d  = addr_q + 16'd1;
          state_d = (cmd == ICE_CMD_READ) ? ST_TX_HI : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TX_HI: begin
        if (!I_TX_FULL) begin
          O_TX_WRITE = 1'b1;
          O_TX_DATA  = data_q[15:8];
          state_d    = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        if (!I_TX_FULL) begin
          O_TX_WRITE = 1'b1;
          O_TX_DATA  = data_q[7:0];
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset kills strobes in the cycle it is seen, not one cycle later.
    if (I_RESET) begin
      O_RX_READ   = 1'b0;
      O_TX_WRITE  = 1'b0;
      O_TX_DATA   = 8'h00;
      O_MEM_REQ   = 1'b0;
      O_MEM_WE    = 1'b0;
      O_CORE_STEP = 1'b0;
    end
  end

  assign O_MEM_ADDR   = addr_q[ADDR_W-1:0];
  assign O_MEM_WDATA  = data_q;
  assign O_CORE_RESET = core_rst_q;
  assign O_CORE_HALT  = halt_q;

endmodule

// File: tb/tb_ice_bridge.sv
// Directed bench for ice_bridge with RX/TX FIFO and RAM models.
module tb_ice_bridge;

  logic        CLK = 1'b0;
  logic        I_RESET;
  logic [7:0]  I_RX_DATA;
  logic        I_RX_PRESENT;
  logic        O_RX_READ;
  logic [7:0]  O_TX_DATA;
  logic        O_TX_WRITE;
  logic        I_TX_FULL;
  logic        O_MEM_REQ;
  logic        I_MEM_GNT;
  logic        O_MEM_WE;
  logic [12:0] O_MEM_ADDR;
  logic [15:0] O_MEM_WDATA;
  logic [15:0] I_MEM_RDATA;
  logic        O_CORE_RESET;
  logic        O_CORE_HALT;
  logic        O_CORE_STEP;
  logic [15:0] I_CORE_PC;

  ice_bridge #(.ADDR_W(13), .MEM_LAT(2)) dut (
    .CLK(CLK), .I_RESET(I_RESET),
    .I_RX_DATA(I_RX_DATA), .I_RX_PRESENT(I_RX_PRESENT), .O_RX_READ(O_RX_READ),
    .O_TX_DATA(O_TX_DATA), .O_TX_WRITE(O_TX_WRITE), .I_TX_FULL(I_TX_FULL),
    .O_MEM_REQ(O_MEM_REQ), .I_MEM_GNT(I_MEM_GNT), .O_MEM_WE(O_MEM_WE),
    .O_MEM_ADDR(O_MEM_ADDR), .O_MEM_WDATA(O_MEM_WDATA), .I_MEM_RDATA(I_MEM_RDATA),
    .O_CORE_RESET(O_CORE_RESET), .O_CORE_HALT(O_CORE_HALT),
    .O_CORE_STEP(O_CORE_STEP), .I_CORE_PC(I_CORE_PC)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [15:0] mem [0:8191];
  logic [15:0] rd_p1, rd_p2;
  logic        pop_pend = 1'b0;
  int          rx_pops = 0, we_cnt = 0, we_nogrant = 0, steps = 0;
  logic [12:0] we_addr;
  logic [15:0] we_data;

  assign I_MEM_RDATA = rd_p2;

  // Two-cycle read pipeline on the RAM model.
  always @(posedge CLK) begin
    rd_p1 <= mem[O_MEM_ADDR];
    rd_p2 <= rd_p1;
  end

  always @(negedge CLK) begin
    if (O_RX_READ) begin
      rx_pops++;
      pop_pend = 1'b1;
    end
    if (O_MEM_WE) begin
      we_cnt++;
      we_addr = O_MEM_ADDR;
      we_data = O_MEM_WDATA;
      mem[O_MEM_ADDR] = O_MEM_WDATA;
      if (!I_MEM_GNT) we_nogrant++;
    end
    if (O_TX_WRITE) txq.push_back(O_TX_DATA);
    if (O_CORE_STEP) steps++;
  end

  always @(posedge CLK) begin
    #1;
    if (pop_pend) begin
      rxq.delete(0);
      pop_pend = 1'b0;
    end
    I_RX_PRESENT = (rxq.size() != 0);
    I_RX_DATA    = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  int pops0, we0;
  bit seen;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[13'h0013] = 16'h1234;
    I_RESET = 1'b1; I_RX_PRESENT = 1'b0; I_RX_DATA = 8'h00;
    I_TX_FULL = 1'b0; I_MEM_GNT = 1'b1; I_CORE_PC = 16'h0000;
    cycles(4);
    chk("rst_mem_req", O_MEM_REQ, 0);
    chk("rst_addr", O_MEM_ADDR, 0);
    chk("rst_wdata", O_MEM_WDATA, 0);
    chk("rst_core_rst", O_CORE_RESET, 0);
    chk("rst_halt", O_CORE_HALT, 0);
    I_RESET = 1'b0;
    cycles(2);

    // Set address 0x0012, data 0xBAED, then write.
    send(8'h02); send(8'h11); send(8'h20); send(8'h30);
    send(8'h4D); send(8'h5E); send(8'h6A); send(8'h7B); send(8'h80);
    cycles(45);
    chk("wr_we_count", we_cnt, 1);
    chk("wr_addr", we_addr, 13'h0012);
    chk("wr_data", we_data, 16'hBAED);
    chk("wr_addr_inc", O_MEM_ADDR, 13'h0013);
    chk("wr_wdata", O_MEM_WDATA, 16'hBAED);
    chk("wr_rx_drained", rxq.size(), 0);

    // Read back RAM[0x0013] = 0x1234.
    txq.delete();
    send(8'h03); send(8'h11); send(8'h90);
    cycles(25);
    chk("rd_tx_n", txq.size(), 2);
    chk("rd_tx_hi", txq[0], 8'h12);
    chk("rd_tx_lo", txq[1], 8'h34);
    chk("rd_addr_inc", O_MEM_ADDR, 13'h0014);
    chk("rd_data_reg", O_MEM_WDATA, 16'h1234);

    // Write with grant held off; a second byte must wait in the FIFO.
    I_MEM_GNT = 1'b0;
    pops0 = rx_pops; we0 = we_cnt;
    send(8'h80); send(8'h45);
    cycles(25);
    chk("gnt_req_held", O_MEM_REQ, 1);
    chk("gnt_no_we", we_cnt, we0);
    chk("gnt_no_pop", rx_pops, pops0 + 1);
    I_MEM_GNT = 1'b1;
    cycles(20);
    chk("gnt_we_once", we_cnt, we0 + 1);
    chk("gnt_we_addr", we_addr, 13'h0014);
    chk("gnt_we_data", we_data, 16'h1234);
    chk("gnt_next_byte", O_MEM_WDATA, 16'h1235);
    chk("gnt_addr_inc", O_MEM_ADDR, 13'h0015);
    chk("gnt_req_drop", O_MEM_REQ, 0);

    // Core control.
    send(8'hB2);
    cycles(6);
    chk("ctl_halt_set", O_CORE_HALT, 1);
    send(8'hB4); send(8'hB4); send(8'hB3); send(8'hB4);
    cycles(20);
    chk("ctl_steps", steps, 2);
    chk("ctl_halt_clr", O_CORE_HALT, 0);
    send(8'hB1);
    cycles(6);
    chk("ctl_core_rst", O_CORE_RESET, 1);
    txq.delete();
    I_CORE_PC = 16'h0042;
    send(8'hB6); send(8'hA0);
    cycles(15);
    chk("pc_tx_n", txq.size(), 2);
    chk("pc_tx_hi", txq[0], 8'h00);
    chk("pc_tx_lo", txq[1], 8'h42);

    // TX back-pressure.
    txq.delete();
    I_TX_FULL = 1'b1;
    pops0 = rx_pops;
    send(8'hA0); send(8'h4C);
    cycles(15);
    chk("bp_no_tx", txq.size(), 0);
    chk("bp_no_pop", rx_pops, pops0 + 1);
    I_TX_FULL = 1'b0;
    cycles(15);
    chk("bp_tx_n", txq.size(), 2);
    chk("bp_tx_hi", txq[0], 8'h00);
    chk("bp_tx_lo", txq[1], 8'h42);
    chk("bp_next_byte", O_MEM_WDATA, 16'h004C);

    // Reset while the read sits in its wait phase.
    txq.delete();
    send(8'h90);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (O_MEM_REQ) seen = 1'b1;
    end
    chk("rr_req_seen", seen, 1);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    I_RESET = 1'b1;
    @(negedge CLK);
    chk("rr_req_same_cycle", O_MEM_REQ, 0);
    @(negedge CLK);
    chk("rr_req", O_MEM_REQ, 0);
    chk("rr_we", O_MEM_WE, 0);
    chk("rr_txw", O_TX_WRITE, 0);
    chk("rr_rxr", O_RX_READ, 0);
    chk("rr_step", O_CORE_STEP, 0);
    chk("rr_core_rst", O_CORE_RESET, 0);
    chk("rr_halt", O_CORE_HALT, 0);
    chk("rr_addr", O_MEM_ADDR, 0);
    chk("rr_wdata", O_MEM_WDATA, 0);
    chk("rr_txd", O_TX_DATA, 0);
    #1;
    I_RESET = 1'b0;
    cycles(15);
    chk("rr_no_tx", txq.size(), 0);
    chk("we_needs_grant", we_nogrant, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
